// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the KS0108 panel controller: FSM encodings and
// the panel command bytes.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        PANEL_RST,
        PANEL_WAIT,
        CMD_ON,
        CMD_START,
        FETCH,
        SET_PAGE,
        SET_COL,
        WR_DATA
    } ctrl_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_HIGH,
        BUS_LOW
    } bus_phase_e;

    localparam logic [7:0] CMD_DISP_ON = 8'h3F;
    localparam logic [7:0] CMD_START0  = 8'hC0;
    localparam logic [7:0] CMD_PAGE    = 8'hB8;
    localparam logic [7:0] CMD_COL     = 8'h40;

    localparam logic [1:0] CS_BOTH = 2'b11;
    localparam logic [1:0] CS_NONE = 2'b00;

endpackage

// File: rtl/lcd_ctrl_bus_wr.sv
// Single-transaction E-strobe sequencer: SETUP, E high, E low with the bus
// held, then a one-cycle done pulse back in idle.
module lcd_bus_wr
    import lcd_ctrl_pkg::*;
#(
    parameter int E_HIGH_CYC = 50,
    parameter int E_LOW_CYC  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       di,
    input  logic [7:0] wr_byte,
    output logic       busy,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_di,
    output logic [7:0] lcd_data,
    output logic [1:0] lcd_cs
);

    localparam int E_MAX = (E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC;
    localparam int CNT_W = $clog2(E_MAX + 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(E_LOW_CYC - 1);

    bus_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             di_q, di_d;
    logic             en_q, en_d;
    logic [1:0]       cs_q, cs_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= BUS_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            di_q    <= 1'b0;
            en_q    <= 1'b0;
            cs_q    <= CS_NONE;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            di_q    <= di_d;
            en_q    <= en_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        di_d    = di_q;
        done_d  = 1'b0;
        case (phase_q)
            BUS_IDLE: begin
                if (start) begin
                    phase_d = BUS_SETUP;
                    data_d  = wr_byte;
                    di_d    = di;
                end
            end
            BUS_SETUP: begin
                phase_d = BUS_HIGH;
                cnt_d   = '0;
            end
            BUS_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    phase_d = BUS_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUS_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    phase_d = BUS_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: phase_d = BUS_IDLE;
        endcase
        // Pins are registered from the next phase so E and CS never glitch.
        en_d = (phase_d == BUS_HIGH);
        cs_d = (phase_d != BUS_IDLE) ? CS_BOTH : CS_NONE;
    end

    assign busy     = (phase_q != BUS_IDLE);
    assign done     = done_q;
    assign lcd_en   = en_q;
    assign lcd_di   = di_q;
    assign lcd_data = data_q;
    assign lcd_cs   = cs_q;

endmodule

// File: rtl/lcd_ctrl.sv
// KS0108 128x64 panel controller: panel init, then pulls column bytes from
// upstream and writes them mirrored to both halves, with page/column commands.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int E_HIGH_CYC = 50,
    parameter int E_LOW_CYC  = 50,
    parameter int RST_CYC    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       data_req,
    output logic       lcd_rst,
    output logic [1:0] lcd_cs,
    output logic       lcd_rw,
    output logic       lcd_di,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

    ctrl_state_e      state_q, state_d;
    logic [RST_W-1:0] wait_q, wait_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;

    logic       wr_req;
    logic       wr_start;
    logic       wr_di;
    logic [7:0] wr_byte;
    logic       bus_busy;
    logic       bus_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PANEL_RST;
            wait_q  <= '0;
            cnt_q   <= 9'd0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        case (state_q)
            PANEL_RST: begin
                if (wait_q == RST_LAST) begin
                    state_d = PANEL_WAIT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            PANEL_WAIT: begin
                if (wait_q == RST_LAST) begin
                    state_d = CMD_ON;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CMD_ON:    if (bus_done) state_d = CMD_START;
            CMD_START: if (bus_done) state_d = FETCH;
            FETCH: begin
                if (din_valid) begin
                    byte_d  = din;
                    state_d = (cnt_q[5:0] == 6'd0) ? SET_PAGE : WR_DATA;
                end
            end
            SET_PAGE: if (bus_done) state_d = SET_COL;
            SET_COL:  if (bus_done) state_d = WR_DATA;
            WR_DATA: begin
                // The 9-bit counter wraps from 511 to 0 on its own.
                if (bus_done) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = PANEL_RST;
        endcase
    end

    always_comb begin
        wr_req     = 1'b0;
        wr_di      = 1'b0;
        wr_byte    = 8'h00;
        data_req   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            CMD_ON: begin
                wr_req  = 1'b1;
                wr_byte = CMD_DISP_ON;
            end
            CMD_START: begin
                wr_req  = 1'b1;
                wr_byte = CMD_START0;
            end
            FETCH: data_req = ~din_valid;
            SET_PAGE: begin
                wr_req  = 1'b1;
                wr_byte = CMD_PAGE | {5'b00000, cnt_q[8:6]};
            end
            SET_COL: begin
                wr_req  = 1'b1;
                wr_byte = CMD_COL;
            end
            WR_DATA: begin
                wr_req     = 1'b1;
                wr_di      = 1'b1;
                wr_byte    = byte_q;
                frame_done = bus_done & (cnt_q == 9'd511);
            end
            default: ;
        endcase
        // Holding off during the done cycle keeps each state to exactly one write.
        wr_start = wr_req & ~bus_busy & ~bus_done;
    end

    assign lcd_rst = (state_q != PANEL_RST);
    assign lcd_rw  = 1'b0;

    lcd_bus_wr #(
        .E_HIGH_CYC(E_HIGH_CYC),
        .E_LOW_CYC (E_LOW_CYC)
    ) u_bus_wr (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .di      (wr_di),
        .wr_byte (wr_byte),
        .busy    (bus_busy),
        .done    (bus_done),
        .lcd_en  (lcd_en),
        .lcd_di  (lcd_di),
        .lcd_data(lcd_data),
        .lcd_cs  (lcd_cs)
    );

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Downstream consumer of the RAM controller's byte stream; drives a KS0108-style 128×64 graphic LCD (two 64-column halves, 8 pages × 8 rows each). Pulls one column byte at a time over the `en`/`data_valid` handshake and writes it to the panel with proper E-strobe timing. Inserts page/column address commands at every page boundary. After a one-time panel init sequence it loops forever, redrawing 512-byte frames mirrored to both halves.

## Interface
- `E_HIGH_CYC`, default 50: clk cycles E is held high per bus write (≥450 ns at 100 MHz).
- `E_LOW_CYC`, default 50: clk cycles E is held low after each write, with bus data held.
- `RST_CYC`, default 1000: cycles `lcd_rst` is held low, and again the cycles waited after release.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high, single clock domain.
- `din` in 8: column byte from RAM controller (`data_out`); bit 0 = top row of page.
- `din_valid` in 1: `din` is valid this cycle (`data_valid`).
- `data_req` out 1: byte request to RAM controller (`en`).
- `lcd_rst` out 1: panel reset, active-low.
- `lcd_cs` out 2: chip selects, `[0]` left, `[1]` right, active-high.
- `lcd_rw` out 1: constant 0 (write only).
- `lcd_di` out 1: 0 = command, 1 = display data.
- `lcd_en` out 1: E strobe; panel latches on falling edge.
- `lcd_data` out 8: panel data bus.
- `frame_done` out 1: one-cycle pulse after byte 511 of a frame is written.

## Operation
- FSM states: `PANEL_RST`, `PANEL_WAIT`, `CMD_ON`, `CMD_START`, `FETCH`, `SET_PAGE`, `SET_COL`, `WR_DATA`.
- `PANEL_RST`: `lcd_rst`=0 for `RST_CYC` cycles → `PANEL_WAIT`: `lcd_rst`=1 for `RST_CYC` cycles → `CMD_ON`.
- `CMD_ON` writes command 0x3F (display on). `CMD_START` writes 0xC0 (start line 0). Then → `FETCH`.
- `FETCH`: `data_req` = (state==`FETCH`) & ~`din_valid`, combinational. Request stays high until `din_valid` is seen, so bytes requested while upstream is between pages are not lost. On `din_valid`, latch `din`. If col==0 → `SET_PAGE`, else → `WR_DATA`.
- `SET_PAGE` writes 0xB8|page. `SET_COL` writes 0x40 (column 0). Then → `WR_DATA`.
- `WR_DATA` writes the latched byte with `lcd_di`=1. Then the byte counter increments and the FSM returns to `FETCH`.
- Byte counter is 9 bits: page = cnt[8:6], col = cnt[5:0]. The panel auto-increments its column, so only page starts need address commands.
- At cnt==511 the counter wraps to 0 and `frame_done` pulses the cycle the write completes.
- `lcd_cs` = 2'b11 for all writes (mirrored image); 2'b00 when idle.
- Exactly one byte is consumed per `din_valid`. A `din_valid` outside `FETCH` is ignored; this cannot occur with a correct upstream.

## Timing
- One bus write takes 1 + `E_HIGH_CYC` + `E_LOW_CYC` cycles:
  - SETUP, 1 cycle: cs/di/data driven, E=0.
  - HIGH: E=1.
  - LOW: E=0, data/di/cs held.
- `lcd_data`/`lcd_di`/`lcd_cs` must not change while E=1 or on the falling edge.
- Fetch latency: `din_valid` arrives 1 cycle after the accepted `data_req`. `data_req` drops combinationally in the cycle `din_valid` is high.
- Reset values: `lcd_rst`=0, `lcd_cs`=0, `lcd_rw`=0, `lcd_di`=0, `lcd_en`=0, `lcd_data`=0, `data_req`=0, `frame_done`=0, counter=0, state=`PANEL_RST`.
- `rst` mid-write aborts immediately: E drops to 0 and the full init sequence reruns.
- Byte-order lockstep with upstream relies on both blocks leaving reset together; no resync mechanism.

## Structure
- Shared package holds:
  - state encoding;
  - command constants `CMD_DISP_ON`=0x3F, `CMD_START0`=0xC0, `CMD_PAGE`=0xB8, `CMD_COL`=0x40.
- Sub-module `lcd_bus_wr`:
  - single-transaction E-strobe sequencer;
  - inputs `start`, `di`, `byte`; outputs `busy`, `done` (1-cycle pulse on return to idle) and the panel pins;
  - owns the `E_HIGH_CYC`/`E_LOW_CYC` counter.
- `lcd_ctrl` holds the FSM, byte counter, latched byte and request logic.

## Test plan
Benches use `E_HIGH_CYC`=2, `E_LOW_CYC`=2, `RST_CYC`=4.
- Reset release: `lcd_rst` low for 4 cycles, high; first E strobe ≥4 cycles later. Bus sequence is 0x3F (di=0), then 0xC0 (di=0).
- First byte: `din_valid` with `din`=0xA5 one cycle after `data_req`. Bus shows 0xB8, 0x40 (di=0), then 0xA5 (di=1), `lcd_cs`=2'b11. Each write: E high exactly 2 cycles, data stable 1 cycle before and 2 cycles after.
- Stalled upstream: withhold `din_valid` for 10 cycles. `data_req` stays high throughout and no E strobe occurs. Valid 0x3C is then written once.
- Page boundary: after 64 bytes, next write sequence is 0xB9, 0x40, data. After 512 bytes, `frame_done` pulses once and 0xB8 follows.
- Reset mid-strobe: assert `rst` while E=1. Next cycle E=0 and `lcd_rst`=0; the init sequence repeats.
- Model test: bench model of the RAM controller's 8-cycle page gaps over a full frame. All 512 bytes arrive on the bus in order with no duplicates or drops.
